// File: rtl/ym2149_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : ym2149_bus_responder
// Purpose  : Responder side of the YM2149 BDIR/BC1/DA bus. It samples the bus
//            phase every clock and holds the 16-entry PSG register file, with
//            per-register bit masks. It also provides high-nibble chip select,
//            I/O ports A/B and the registered read-back path.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   cpu_clock   in   1   system clock, bus sampled on rising edge
//   reset       in   1   asynchronous, active-low reset
//   bdir, bc1   in   1   bus mode {bdir,bc1}: 00 idle, 01 read, 10 write, 11 latch
//   da_in       in   8   DA bus value from the CPU side
//   da_out      out  8   read data (8'h00 whenever da_oe=0)
//   da_oe       out  1   da_out drives the DA bus
//   ioa_in      in   8   port A pins
//   iob_in      in   8   port B pins
//   ioa_out     out  8   R14 when R7[6]=1, else 8'h00
//   iob_out     out  8   R15 when R7[7]=1, else 8'h00
//   regs_flat   out 128  masked register image, R0 at [7:0] .. R15 at [127:120]
//   env_restart out  1   one-cycle pulse after a committed write to R13
// ============================================================================
module ym2149_bus_responder #(
  parameter logic [3:0] CHIP_ADDR  = 4'h0,
  parameter logic       ADDR_CHECK = 1'b1
) (
  input  logic         cpu_clock,
  input  logic         reset,
  input  logic         bdir,
  input  logic         bc1,
  input  logic [7:0]   da_in,
  output logic [7:0]   da_out,
  output logic         da_oe,
  input  logic [7:0]   ioa_in,
  input  logic [7:0]   iob_in,
  output logic [7:0]   ioa_out,
  output logic [7:0]   iob_out,
  output logic [127:0] regs_flat,
  output logic         env_restart
);

  // State encoding equals the bus mode, so next state is the sampled mode.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_LATCH = 2'b11
  } state_t;

  state_t      state;
  state_t      mode;
  logic [7:0]  da_q;       // da_in from the most recent cycle of the current phase
  logic [3:0]  addr;
  logic        selected;
  logic [7:0]  regs [16];
  logic [7:0]  read_val;
  logic        reading;

  assign mode    = state_t'({bdir, bc1});
  assign reading = (state == ST_READ) && selected;

  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13:  reg_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10:  reg_mask = 8'h1F;
      default:                  reg_mask = 8'hFF;
    endcase
  endfunction

  // Port registers read back the pins when the port is configured as input.
  always_comb begin
    read_val = regs[addr];
    if (addr == 4'd14 && !regs[7][6]) read_val = ioa_in;
    if (addr == 4'd15 && !regs[7][7]) read_val = iob_in;
  end

  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      da_q        <= 8'h00;
      addr        <= 4'h0;
      selected    <= 1'b1;
      env_restart <= 1'b0;
      da_oe       <= 1'b0;
      da_out      <= 8'h00;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      state       <= mode;
      da_q        <= da_in;
      env_restart <= 1'b0;

      // A phase acts when it ends, using the value captured on its last cycle.
      if (state != mode) begin
        case (state)
          ST_LATCH: begin
            addr     <= da_q[3:0];
            selected <= !ADDR_CHECK || (da_q[7:4] == CHIP_ADDR);
          end
          ST_WRITE: begin
            if (selected) begin
              regs[addr] <= da_q & reg_mask(addr);
              if (addr == 4'd13) env_restart <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Driven one cycle after READ is entered, released one cycle after it ends.
      da_oe  <= reading;
      da_out <= reading ? read_val : 8'h00;
    end
  end

  assign ioa_out = regs[7][6] ? regs[14] : 8'h00;
  assign iob_out = regs[7][7] ? regs[15] : 8'h00;

  for (genvar gi = 0; gi < 16; gi++) begin : g_flat
    assign regs_flat[8*gi +: 8] = regs[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_ym2149_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ym2149_bus_responder
// Purpose  : Self-checking bench. Two responders share one bus (chip 0 and
//            chip 1), so chip select can be observed. A transaction-level model
//            predicts registers, read data, port outputs and envelope pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ym2149_bus_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         bdir = 1'b0, bc1 = 1'b0;
  logic [7:0]   da_in = 8'h00, ioa_in = 8'h00, iob_in = 8'h00;
  logic [7:0]   da_out [2];
  logic         da_oe [2];
  logic [7:0]   ioa_out [2];
  logic [7:0]   iob_out [2];
  logic [127:0] regs_flat [2];
  logic         env_restart [2];

  always #5 clk = ~clk;

  ym2149_bus_responder #(.CHIP_ADDR(4'h0), .ADDR_CHECK(1'b1)) dut (
    .cpu_clock(clk), .reset(rst_n), .bdir(bdir), .bc1(bc1), .da_in(da_in),
    .da_out(da_out[0]), .da_oe(da_oe[0]), .ioa_in(ioa_in), .iob_in(iob_in),
    .ioa_out(ioa_out[0]), .iob_out(iob_out[0]), .regs_flat(regs_flat[0]),
    .env_restart(env_restart[0]));

  ym2149_bus_responder #(.CHIP_ADDR(4'h1), .ADDR_CHECK(1'b1)) dut1 (
    .cpu_clock(clk), .reset(rst_n), .bdir(bdir), .bc1(bc1), .da_in(da_in),
    .da_out(da_out[1]), .da_oe(da_oe[1]), .ioa_in(ioa_in), .iob_in(iob_in),
    .ioa_out(ioa_out[1]), .iob_out(iob_out[1]), .regs_flat(regs_flat[1]),
    .env_restart(env_restart[1]));

  int n_pass = 0;
  int n_total = 0;

  // Reference model: one register array, address and select flag per chip.
  logic [7:0] m_regs [2][16];
  logic [3:0] m_addr [2];
  logic       m_sel  [2];

  logic [7:0] last_rd0;
  logic       last_oe0;
  logic       last_env0;

  localparam int OP_LATCH = 0, OP_WRITE = 1, OP_READ = 2;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] spec_mask(input int a);
    if (a inside {1, 3, 5, 13}) return 8'h0F;
    if (a inside {6, 8, 9, 10}) return 8'h1F;
    return 8'hFF;
  endfunction

  function automatic logic [127:0] model_flat(input int c);
    logic [127:0] f = '0;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = m_regs[c][i];
    return f;
  endfunction

  function automatic logic [7:0] model_read(input int c);
    int a = int'(m_addr[c]);
    if (a == 14) return m_regs[c][7][6] ? m_regs[c][14] : ioa_in;
    if (a == 15) return m_regs[c][7][7] ? m_regs[c][15] : iob_in;
    return m_regs[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 16; i++) m_regs[c][i] = 8'h00;
      m_addr[c] = 4'h0;
      m_sel[c]  = 1'b1;
    end
  endtask

  // One bus phase of n cycles (da_in valid only on its last cycle), then idle.
  task automatic do_op(input int op, input logic [7:0] d, input int n);
    logic pulse [2];
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      {bdir, bc1} = (op == OP_LATCH) ? 2'b11 : (op == OP_WRITE) ? 2'b10 : 2'b01;
      da_in = (k == n - 1) ? d : 8'($urandom);
      @(posedge clk);
    end
    #1;
    if (op == OP_READ) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("read_oe[%0d]", c), 128'(da_oe[c]), 128'(m_sel[c]));
        chk($sformatf("read_data[%0d]", c), 128'(da_out[c]),
            128'(m_sel[c] ? model_read(c) : 8'h00));
      end
      last_rd0 = da_out[0];
      last_oe0 = da_oe[0];
    end
    @(negedge clk);
    {bdir, bc1} = 2'b00;
    da_in = 8'($urandom);
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      pulse[c] = 1'b0;
      if (op == OP_LATCH) begin
        m_addr[c] = d[3:0];
        m_sel[c]  = (int'(d[7:4]) == c);
      end else if (op == OP_WRITE && m_sel[c]) begin
        m_regs[c][m_addr[c]] = d & spec_mask(int'(m_addr[c]));
        pulse[c] = (m_addr[c] == 4'd13);
      end
      chk($sformatf("env_pulse[%0d]", c), 128'(env_restart[c]), 128'(pulse[c]));
    end
    last_env0 = env_restart[0];
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("env_low[%0d]", c), 128'(env_restart[c]), 128'(0));
      chk($sformatf("idle_oe[%0d]", c), 128'(da_oe[c]), 128'(0));
      chk($sformatf("idle_da[%0d]", c), 128'(da_out[c]), 128'(0));
      chk($sformatf("regs[%0d]", c), regs_flat[c], model_flat(c));
      chk($sformatf("ioa_out[%0d]", c), 128'(ioa_out[c]),
          128'(m_regs[c][7][6] ? m_regs[c][14] : 8'h00));
      chk($sformatf("iob_out[%0d]", c), 128'(iob_out[c]),
          128'(m_regs[c][7][7] ? m_regs[c][15] : 8'h00));
    end
  endtask

  typedef struct {
    int         op;
    logic [7:0] d;
    int         n;
    logic       chk_rd;
    logic [7:0] exp_da;
    logic       exp_env;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Hand-derived vectors for chip 0.
    tbl[0]  = '{OP_LATCH, 8'h07, 1, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{OP_WRITE, 8'hC0, 1, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{OP_READ,  8'h00, 2, 1'b1, 8'hC0, 1'b0};
    tbl[3]  = '{OP_LATCH, 8'h01, 1, 1'b0, 8'h00, 1'b0};
    tbl[4]  = '{OP_WRITE, 8'hFF, 2, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{OP_LATCH, 8'h08, 1, 1'b0, 8'h00, 1'b0};
    tbl[6]  = '{OP_WRITE, 8'hFF, 1, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{OP_LATCH, 8'h01, 2, 1'b0, 8'h00, 1'b0};
    tbl[8]  = '{OP_READ,  8'h00, 2, 1'b1, 8'h0F, 1'b0};
    tbl[9]  = '{OP_LATCH, 8'h08, 1, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{OP_READ,  8'h00, 3, 1'b1, 8'h1F, 1'b0};
    tbl[11] = '{OP_LATCH, 8'h0D, 1, 1'b0, 8'h00, 1'b0};
    tbl[12] = '{OP_WRITE, 8'h0A, 1, 1'b0, 8'h00, 1'b1};
    tbl[13] = '{OP_WRITE, 8'h0A, 3, 1'b0, 8'h00, 1'b1};
    tbl[14] = '{OP_READ,  8'h00, 2, 1'b1, 8'h0A, 1'b0};
    tbl[15] = '{OP_LATCH, 8'h07, 1, 1'b0, 8'h00, 1'b0};

    // Reset state.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      chk("rst_regs", regs_flat[c], 128'(0));
      chk("rst_oe", 128'(da_oe[c]), 128'(0));
      chk("rst_da", 128'(da_out[c]), 128'(0));
      chk("rst_env", 128'(env_restart[c]), 128'(0));
      chk("rst_ioa", 128'(ioa_out[c]), 128'(0));
      chk("rst_iob", 128'(iob_out[c]), 128'(0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed vectors.
    for (int i = 0; i < 16; i++) begin
      do_op(tbl[i].op, tbl[i].d, tbl[i].n);
      if (tbl[i].chk_rd) begin
        chk($sformatf("tbl%0d_da", i), 128'(last_rd0), 128'(tbl[i].exp_da));
        chk($sformatf("tbl%0d_oe", i), 128'(last_oe0), 128'(1));
      end
      if (tbl[i].op == OP_WRITE)
        chk($sformatf("tbl%0d_env", i), 128'(last_env0), 128'(tbl[i].exp_env));
    end
    chk("tbl_r7", regs_flat[0][63:56], 128'(8'hC0));
    chk("tbl_ioa_r14", 128'(ioa_out[0]), 128'(8'h00));

    // Chip select: chip 1 ignores address 0x02, accepts 0x12.
    do_op(OP_LATCH, 8'h02, 1);
    do_op(OP_WRITE, 8'h55, 1);
    chk("cs_unsel_r2", regs_flat[1][23:16], 128'(8'h00));
    do_op(OP_READ, 8'h00, 2);
    chk("cs_unsel_oe", 128'(da_oe[1]), 128'(0));
    do_op(OP_LATCH, 8'h12, 1);
    do_op(OP_WRITE, 8'h55, 2);
    chk("cs_sel_r2", regs_flat[1][23:16], 128'(8'h55));

    // Port A: input mode reads pins, output mode drives and reads R14.
    do_op(OP_LATCH, 8'h07, 1);
    do_op(OP_WRITE, 8'h00, 1);
    ioa_in = 8'h3C;
    do_op(OP_LATCH, 8'h0E, 1);
    do_op(OP_READ, 8'h00, 2);
    chk("porta_in", 128'(last_rd0), 128'(8'h3C));
    do_op(OP_LATCH, 8'h07, 1);
    do_op(OP_WRITE, 8'h40, 1);
    do_op(OP_LATCH, 8'h0E, 1);
    do_op(OP_WRITE, 8'hA5, 1);
    chk("porta_out", 128'(ioa_out[0]), 128'(8'hA5));
    do_op(OP_READ, 8'h00, 2);
    chk("porta_rd", 128'(last_rd0), 128'(8'hA5));

    // Reset in the middle of a WRITE to R0 abandons the write.
    do_op(OP_LATCH, 8'h00, 1);
    @(negedge clk);
    {bdir, bc1} = 2'b10;
    da_in = 8'h77;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      chk("midrst_regs", regs_flat[c], 128'(0));
      chk("midrst_oe", 128'(da_oe[c]), 128'(0));
      chk("midrst_ioa", 128'(ioa_out[c]), 128'(0));
      chk("midrst_env", 128'(env_restart[c]), 128'(0));
    end
    @(negedge clk);
    {bdir, bc1} = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(OP_LATCH, 8'h00, 1);
    do_op(OP_WRITE, 8'h77, 1);
    chk("post_rst_r0", regs_flat[0][7:0], 128'(8'h77));

    // Randomized transactions against the model.
    for (int i = 0; i < 300; i++) begin
      int op;
      logic [7:0] d;
      ioa_in = 8'($urandom);
      iob_in = 8'($urandom);
      op = $urandom_range(0, 2);
      d  = 8'($urandom);
      if (op == OP_LATCH) d[7:4] = 4'($urandom_range(0, 2));
      do_op(op, d, (op == OP_READ) ? $urandom_range(2, 3) : $urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
